// File: rtl/layer_backprop_if.sv
// Handshake/bus bundle for layer_backprop.
// master: the side that supplies inputs and consumes prev_deltas.
// slave: the layer_backprop block itself.
interface layer_backprop_if #(
  parameter int NEURON_NUM        = 5,
  parameter int DELTA_CELL_WIDTH  = 10,
  parameter int WEIGHT_CELL_WIDTH = 16
);
  localparam int CNT_W = $clog2(NEURON_NUM) + 1;

  logic [CNT_W-1:0]                                 curr_neurons;
  logic                                             curr_neurons_valid;
  logic                                             curr_neurons_ready;
  logic [CNT_W-1:0]                                 prev_neurons;
  logic                                             prev_neurons_valid;
  logic                                             prev_neurons_ready;
  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]           deltas;
  logic                                             deltas_valid;
  logic                                             deltas_ready;
  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] weights;
  logic                                             weights_valid;
  logic                                             weights_ready;
  logic [NEURON_NUM*DELTA_CELL_WIDTH-1:0]           prev_deltas;
  logic                                             overflow;
  logic                                             prev_deltas_valid;
  logic                                             prev_deltas_ready;

  modport master (
    output curr_neurons, curr_neurons_valid, prev_neurons, prev_neurons_valid,
    output deltas, deltas_valid, weights, weights_valid, prev_deltas_ready,
    input  curr_neurons_ready, prev_neurons_ready, deltas_ready, weights_ready,
    input  prev_deltas, overflow, prev_deltas_valid
  );

  modport slave (
    input  curr_neurons, curr_neurons_valid, prev_neurons, prev_neurons_valid,
    input  deltas, deltas_valid, weights, weights_valid, prev_deltas_ready,
    output curr_neurons_ready, prev_neurons_ready, deltas_ready, weights_ready,
    output prev_deltas, overflow, prev_deltas_valid
  );
endinterface

// File: rtl/layer_backprop.sv
// layer_backprop: prev_deltas[j] = sum_i w[i][j] * deltas[i], one current
// neuron per cycle, all previous neurons in parallel.
// Optional feature macro: LAYER_BACKPROP_SATURATE_EN -- when defined,
// out-of-range results clamp to the delta range instead of wrapping.
module layer_backprop #(
  parameter int NEURON_NUM        = 5,
  parameter int DELTA_CELL_WIDTH  = 10,
  parameter int WEIGHT_CELL_WIDTH = 16,
  parameter int FRACTION          = 0
) (
  input  logic          clk,
  input  logic          rst,
  layer_backprop_if.slave bus
);
  localparam int N      = NEURON_NUM;
  localparam int D      = DELTA_CELL_WIDTH;
  localparam int W      = WEIGHT_CELL_WIDTH;
  localparam int CNT_W  = $clog2(N) + 1;
  localparam int IDX_W  = $clog2(N);
  localparam int PROD_W = W + D;
  localparam int ACC_W  = W + D + $clog2(N) + 1;

  localparam logic [CNT_W-1:0]        N_CNT   = CNT_W'(N);
  localparam logic signed [ACC_W-1:0] MAX_ACC = ACC_W'(2 ** (D - 1) - 1);
  localparam logic signed [ACC_W-1:0] MIN_ACC = -ACC_W'(2 ** (D - 1));

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;
  state_t state_reg, state_next;

  // Channel order in the 4-bit vectors: 0 curr, 1 prev, 2 deltas, 3 weights.
  logic [3:0]             held_reg, held_next, ready_reg, ready_next, fire;
  logic [CNT_W-1:0]       curr_reg, prev_reg, curr_next;
  logic [CNT_W-1:0]       n_cur, n_start;
  logic [N*D-1:0]         deltas_reg;
  logic [N*N*W-1:0]       weights_reg;
  logic [CNT_W-1:0]       i_reg;
  logic [IDX_W-1:0]       idx;
  logic                   start, out_fire;
  logic [N*D-1:0]         prev_deltas_reg, prev_deltas_red;
  logic                   overflow_reg, valid_reg;
  logic [N-1:0]           ovf_j;
  logic signed [D-1:0]    d_arr [N];
  logic signed [W-1:0]    w_arr [N][N];
  logic signed [D-1:0]    d_sel;

  assign fire[0]  = bus.curr_neurons_valid & ready_reg[0];
  assign fire[1]  = bus.prev_neurons_valid & ready_reg[1];
  assign fire[2]  = bus.deltas_valid       & ready_reg[2];
  assign fire[3]  = bus.weights_valid      & ready_reg[3];
  assign out_fire = (state_reg == DONE) & valid_reg & bus.prev_deltas_ready;

  // curr_neurons may be latched on the same edge the operation starts.
  assign curr_next = fire[0] ? bus.curr_neurons : curr_reg;
  assign n_start   = (curr_next > N_CNT) ? N_CNT : curr_next;
  assign n_cur     = (curr_reg  > N_CNT) ? N_CNT : curr_reg;
  assign idx       = i_reg[IDX_W-1:0];
  assign d_sel     = d_arr[idx];

  // Held flags set on each input handshake, all cleared by the output handshake.
  always_comb begin
    held_next = held_reg | fire;
    if (out_fire) held_next = '0;
  end

  // Next-state logic; start marks the edge that clears the accumulators.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    case (state_reg)
      LOAD: begin
        if (&held_next) begin
          start      = 1'b1;
          state_next = (n_start == '0) ? DONE : COMPUTE;
        end
      end
      COMPUTE: begin
        if (i_reg == n_cur - 1'b1) state_next = DONE;
      end
      DONE: begin
        if (out_fire) state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
    ready_next = (state_next == LOAD) ? ~held_next : 4'b0000;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= LOAD;
    else      state_reg <= state_next;
  end

  // Held flags and registered readies (readies stay low through reset).
  always_ff @(posedge clk) begin
    if (!rst) begin
      held_reg  <= '0;
      ready_reg <= '0;
    end else begin
      held_reg  <= held_next;
      ready_reg <= ready_next;
    end
  end

  // Input capture registers; guarded by the held flags, so no reset needed.
  always_ff @(posedge clk) begin
    if (fire[0]) curr_reg    <= bus.curr_neurons;
    if (fire[1]) prev_reg    <= bus.prev_neurons;
    if (fire[2]) deltas_reg  <= bus.deltas;
    if (fire[3]) weights_reg <= bus.weights;
  end

  // Current-neuron index walks 0..n-1 during COMPUTE.
  always_ff @(posedge clk) begin
    if (!rst)                       i_reg <= '0;
    else if (start)                 i_reg <= '0;
    else if (state_reg == COMPUTE)  i_reg <= i_reg + 1'b1;
  end

  // Unpack the captured vectors into indexable arrays.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign d_arr[gi] = deltas_reg[gi*D +: D];
    for (genvar gj = 0; gj < N; gj++) begin : g_w
      assign w_arr[gi][gj] = weights_reg[(gi*N+gj)*W +: W];
    end
  end

  // One accumulator and output reducer per previous-layer neuron.
  for (genvar gi = 0; gi < N; gi++) begin : g_col
    logic signed [PROD_W-1:0] prod, prod_sh;
    logic signed [ACC_W-1:0]  term, acc_reg;
    logic [D-1:0]             red;
    logic                     hi, lo, active;

    assign prod    = w_arr[idx][gi] * d_sel;
    assign prod_sh = prod >>> FRACTION;
    assign term    = {{(ACC_W-PROD_W){prod_sh[PROD_W-1]}}, prod_sh};

    // Accumulate w[i][j]*delta[i] for the current i.
    always_ff @(posedge clk) begin
      if (!rst)                       acc_reg <= '0;
      else if (start)                 acc_reg <= '0;
      else if (state_reg == COMPUTE)  acc_reg <= acc_reg + term;
    end

    assign hi        = acc_reg > MAX_ACC;
    assign lo        = acc_reg < MIN_ACC;
    assign active    = CNT_W'(gi) < prev_reg;
    assign ovf_j[gi] = active & (hi | lo);
`ifdef LAYER_BACKPROP_SATURATE_EN
    localparam logic [D-1:0] MAX_D = {1'b0, {(D-1){1'b1}}};
    localparam logic [D-1:0] MIN_D = {1'b1, {(D-1){1'b0}}};
    assign red = hi ? MAX_D : (lo ? MIN_D : acc_reg[D-1:0]);
`else
    assign red = acc_reg[D-1:0];
`endif
    assign prev_deltas_red[gi*D +: D] = active ? red : '0;
  end

  // Output register: captured once on entering DONE, held until handshake.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_deltas_reg <= '0;
      overflow_reg    <= 1'b0;
      valid_reg       <= 1'b0;
    end else if (state_reg == DONE && !valid_reg) begin
      prev_deltas_reg <= prev_deltas_red;
      overflow_reg    <= |ovf_j;
      valid_reg       <= 1'b1;
    end else if (out_fire) begin
      valid_reg       <= 1'b0;
    end
  end

  assign bus.curr_neurons_ready = ready_reg[0];
  assign bus.prev_neurons_ready = ready_reg[1];
  assign bus.deltas_ready       = ready_reg[2];
  assign bus.weights_ready      = ready_reg[3];
  assign bus.prev_deltas        = prev_deltas_reg;
  assign bus.overflow           = overflow_reg;
  assign bus.prev_deltas_valid  = valid_reg;
endmodule

// File: doc/layer_backprop.md
# layer_backprop

Backward-pass counterpart of the forward `layer` block. It takes the error deltas of the current layer and the same weight matrix the forward pass used, and computes the deltas of the previous layer: prev_deltas[j] = Σ_i weights[i][j] · deltas[i]. It sits between the output-error stage and the weight-update stage. All inputs and the output use the same valid/ready handshakes as `layer`, so the two blocks can share a weight memory front-end.

## Interface
- NEURON_NUM, 5, maximum neurons per layer.
- DELTA_CELL_WIDTH, 10, signed width of one delta, both input and output.
- WEIGHT_CELL_WIDTH, 16, signed width of one weight.
- FRACTION, 0, number of fractional bits in the weights; each product is shifted right arithmetically by this amount.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-low reset. Sampled on the clk rising edge; rst==0 resets the block.
- curr_neurons  in  log2(NEURON_NUM)+1  number of neurons in the current (delta-source) layer.
- curr_neurons_valid / curr_neurons_ready  in/out  1  handshake for curr_neurons.
- prev_neurons  in  log2(NEURON_NUM)+1  number of neurons in the previous (delta-target) layer.
- prev_neurons_valid / prev_neurons_ready  in/out  1  handshake for prev_neurons.
- deltas  in  NEURON_NUM·DELTA_CELL_WIDTH  current-layer deltas; delta i is at [i·D +: D].
- deltas_valid / deltas_ready  in/out  1  handshake for deltas.
- weights  in  NEURON_NUM²·WEIGHT_CELL_WIDTH  weight matrix; w[i][j] is at [(i·NEURON_NUM+j)·W +: W], where i is the current neuron and j the previous neuron.
- weights_valid / weights_ready  in/out  1  handshake for weights.
- prev_deltas  out  NEURON_NUM·DELTA_CELL_WIDTH  previous-layer deltas, same packing as deltas.
- overflow  out  1  set when any prev_delta exceeded the DELTA_CELL_WIDTH range.
- prev_deltas_valid / prev_deltas_ready  out/in  1  output handshake.

## Operation
- FSM states: LOAD, COMPUTE, DONE.
- LOAD:
  - Each of the four inputs has its own "held" flag and register.
  - Each input's ready is high while its held flag is clear.
  - valid&ready latches the input and sets its flag.
  - Inputs may arrive in any order, in the same cycle or in different cycles.
  - When all four flags are set, go to COMPUTE, clear the accumulators and set index i=0.
- COMPUTE:
  - One current neuron per cycle. For every j in parallel: acc[j] += (w[i][j]·delta[i]) >>> FRACTION.
  - After the cycle with i = n−1, go to DONE, where n = min(curr_neurons, NEURON_NUM).
  - If n==0, go straight from LOAD to DONE with all accumulators at 0.
- Arithmetic:
  - Signed two's-complement throughout.
  - Accumulator width is W+D+log2(NEURON_NUM)+1, which cannot overflow internally.
- Output (DONE):
  - For j < min(prev_neurons, NEURON_NUM), prev_deltas[j] = acc[j] reduced to D bits (see Configuration).
  - For j ≥ prev_neurons, prev_deltas[j] = 0.
  - overflow is the OR, over the active j only, of "acc[j] outside [−2^(D−1), 2^(D−1)−1]".
- DONE:
  - prev_deltas_valid is high.
  - prev_deltas and overflow stay stable until prev_deltas_valid&prev_deltas_ready.
  - On that handshake, clear all held flags and return to LOAD.
- All input readies are low in COMPUTE and DONE.
- Reset (rst==0), including mid-COMPUTE or mid-DONE:
  - State goes to LOAD and all held flags clear.
  - prev_deltas=0, overflow=0, prev_deltas_valid=0.
  - The four input readies are 0 while rst==0 and 1 in the first cycle after release.

## Timing
- Take T as the edge at which the last input is latched. COMPUTE runs on edges T+1 … T+n.
- prev_deltas_valid rises after edge T+n+1, giving a latency of n+1 cycles. For n==0, valid rises after T+1.
- Outputs are registered; no combinational path runs from any valid or ready input to any output.
- The output handshake completes on the edge where valid&ready. The input readies are high from the next cycle.
- Back-to-back operation: new inputs may be latched in the cycle right after the output handshake.

## Configuration
- LAYER_BACKPROP_SATURATE_EN
  - Defined: an out-of-range acc[j] clamps to 2^(D−1)−1 or −2^(D−1).
  - Undefined: prev_deltas[j] is the low D bits of acc[j] (wrap-around).
  - overflow behaves identically in both builds.

## Test plan
- Basic sum: defaults, curr=prev=5, all weights 1, deltas {5,4,3,2,1}. Expected: every prev_delta = 15, overflow=0, valid 6 cycles after the last input.
- Sign and identity: w[i][j]=1 if i==j, else 0; all deltas −3. Expected: every prev_delta = −3 (10'h3FD). Then set prev_neurons=3. Expected: prev_deltas[3] and prev_deltas[4] = 0.
- Overflow: all weights 1000, all deltas 511, n=5. Expected: acc = 2,555,000 and overflow=1. With the macro defined, outputs = 511. Without it, outputs = the low 10 bits.
- Staggered inputs and backpressure:
  - Drive the four valids 3 cycles apart. Expected: each ready drops one cycle after its own handshake.
  - Hold prev_deltas_ready=0 for 20 cycles. Expected: outputs stable and all readies 0 throughout.
  - Release ready. Expected: readies return 1 the next cycle.
- Edge counts: curr_neurons=0. Expected: zeros, valid 1 cycle after the last input. curr_neurons=7. Expected: clamped to 5, identical to the basic-sum result.
- Mid-operation reset: assert rst=0 for one cycle during COMPUTE of the basic-sum case. Expected: valid=0 and outputs 0. Then reapply the inputs. Expected: result 15 with the same latency.
